mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter sitting directly downstream of the CPU's data-memory port (MemWrite / DataAdr / WriteData), alongside the data RAM. CPU stores to a TX address enqueue bytes into a small FIFO; a baud-timed FSM serializes them 8N1 onto a single output pin. A status word is readable through the same address decode so software can poll before writing.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/mmio_uart_tx_if.sv | 27 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/mmio_uart_tx.sv | 156 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter:
// FSM state encoding, default bus addresses and status-word layout.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [31:0] DEFAULT_TX_ADDR     = 32'h0000_0400;
  localparam logic [31:0] DEFAULT_STATUS_ADDR = 32'h0000_0404;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  // Packs the status flags and the zero-extended FIFO count into the
  // word software sees on a load from the status address.
  function automatic logic [31:0] pack_status(
    input logic       empty,
    input logic       full,
    input logic       busy,
    input logic       overflow,
    input logic [7:0] count
  );
    logic [31:0] s;
    s                          = '0;
    s[STAT_EMPTY]              = empty;
    s[STAT_FULL]               = full;
    s[STAT_BUSY]               = busy;
    s[STAT_OVERFLOW]           = overflow;
    s[STAT_COUNT_LSB +: 8]     = count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory port as seen by the UART: store strobe, address and data
// from the CPU, decode hit and read data back to the CPU's load mux.
interface mmio_uart_tx_if;

  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        sel;
  logic [31:0] rd_data;

  modport master (
    output MemWrite,
    output DataAdr,
    output WriteData,
    input  sel,
    input  rd_data
  );

  modport slave (
    input  MemWrite,
    input  DataAdr,
    input  WriteData,
    output sel,
    output rd_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port; a push while full
// is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: entries are only observable once pushed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// CPU-store-driven 8N1 UART transmitter: stores to TX_ADDR queue bytes, the
// FSM serializes them LSB first, and STATUS_ADDR exposes a pollable status word.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = DEFAULT_TX_ADDR,
  parameter logic [31:0] STATUS_ADDR  = DEFAULT_STATUS_ADDR
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;

  logic          tx_hit;
  logic          status_hit;
  logic          push_req;
  logic          clr_req;
  logic          push_acc;
  logic          bit_done;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic [31:0]   status;
  logic          unused_wdata;

  assign tx_hit       = (bus.DataAdr == TX_ADDR);
  assign status_hit   = (bus.DataAdr == STATUS_ADDR);
  assign push_req     = bus.MemWrite && tx_hit;
  assign clr_req      = bus.MemWrite && status_hit && bus.WriteData[STAT_OVERFLOW];
  assign bit_done     = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign unused_wdata = ^bus.WriteData[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (bus.WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Occupancy after this edge, so busy can drop on the very edge entering IDLE.
  assign push_acc   = push_req && (!fifo_full || fifo_pop);
  assign count_next = fifo_count + CW'(push_acc) - CW'(fifo_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next state so the line changes on the same
  // edge the FSM does, with no extra cycle of skew.
  always_comb begin
    fifo_pop  = 1'b0;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (state_q == IDLE) begin
      baud_d    = '0;
      bit_idx_d = '0;
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        shift_d  = fifo_dout;
      end
    end else begin
      baud_d = bit_done ? '0 : baud_q + BW'(1);
      if ((state_q == DATA) && bit_done) begin
        shift_d   = {1'b0, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
      end
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE) || (count_next != '0);

    // A drop in the same cycle as a clear wins, so no overflow goes unseen.
    overflow_d = overflow_q;
    if (clr_req) begin
      overflow_d = 1'b0;
    end
    if (push_req && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    status = pack_status(fifo_empty, fifo_full, busy_q, overflow_q, 8'(fifo_count));
  end

  assign bus.sel     = tx_hit || status_hit;
  assign bus.rd_data = status_hit ? status : '0;
  assign tx          = tx_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: decode/status vector table plus
// frame-level sequences, with a serial monitor checking bytes against a queue.
module tb_mmio_uart_tx;
  import uart_pkg::*;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] TXA   = 32'h0000_0400;
  localparam logic [31:0] STA   = 32'h0000_0404;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic busy;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (TXA),
    .STATUS_ADDR  (STA)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  always @(posedge clk) cycle <= cycle + 1;

  logic [7:0] sb [$];
  int         starts [$];
  int         frames_seen = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Serial monitor: decodes every frame on tx, checks framing and compares
  // the byte with the head of the scoreboard queue.
  bit         mon_active = 1'b0;
  bit         mon_err;
  int         mon_pos;
  logic       mon_bit;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_pos    = 1;
        mon_err    = 1'b0;
        mon_byte   = '0;
        starts.push_back(cycle);
      end
    end else begin
      if (mon_pos < CPB) begin
        if (tx !== 1'b0) mon_err = 1'b1;
      end else if (mon_pos < 9 * CPB) begin
        if ((mon_pos % CPB) == 0) begin
          mon_bit  = tx;
          mon_byte = {tx, mon_byte[7:1]};
        end else if (tx !== mon_bit) begin
          mon_err = 1'b1;
        end
      end else if (tx !== 1'b1) begin
        mon_err = 1'b1;
      end
      mon_pos++;
      if (mon_pos == 10 * CPB) begin
        mon_active = 1'b0;
        frames_seen++;
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_frame: got byte 0x%02h expected no frame", mon_byte);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_byte !== mon_exp || mon_err) begin
            mismatched++;
            $display("[TB] FAIL frame: got byte 0x%02h framing_err=%0d expected byte 0x%02h framing_err=0",
                     mon_byte, mon_err, mon_exp);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic mw, input logic [31:0] adr, input logic [31:0] wd);
    bus.MemWrite  = mw;
    bus.DataAdr   = adr;
    bus.WriteData = wd;
  endtask

  task automatic storeWord(input logic [31:0] adr, input logic [31:0] wd);
    applyStimulus(1'b1, adr, wd);
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic readStatus(input logic [31:0] exp, input string name);
    applyStimulus(1'b0, STA, 32'h0);
    #1;
    checkOutput({name, "_sel"}, 32'(bus.sel), 32'h1);
    checkOutput(name, bus.rd_data, exp);
  endtask

  task automatic waitIdle(input int limit, input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || mon_active) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_idle_in_time"}, 32'(n < limit), 32'h1);
  endtask

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        exp_sel;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs [7];

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;
    int low;
    int frames_before;

    vecs[0] = '{1'b0, TXA,           32'hFFFF_FFFF, 1'b1, 32'h0000_0000, "dec_tx_addr"};
    vecs[1] = '{1'b0, STA,           32'h0000_0000, 1'b1, 32'h0000_0001, "dec_status"};
    vecs[2] = '{1'b0, 32'h0000_0408, 32'h0000_0000, 1'b0, 32'h0000_0000, "dec_0408"};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, "dec_zero"};
    vecs[4] = '{1'b0, 32'h0000_0403, 32'h0000_0000, 1'b0, 32'h0000_0000, "dec_0403"};
    vecs[5] = '{1'b1, STA,           32'h0000_0008, 1'b1, 32'h0000_0001, "dec_status_store"};
    vecs[6] = '{1'b0, 32'h0000_1404, 32'h0000_0000, 1'b0, 32'h0000_0000, "dec_alias"};

    applyStimulus(1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_tx", 32'(tx), 32'h1);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    readStatus(32'h0000_0001, "reset_status");

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].mw, vecs[i].adr, vecs[i].wd);
      #1;
      checkOutput({vecs[i].name, "_sel"}, 32'(bus.sel), 32'(vecs[i].exp_sel));
      checkOutput({vecs[i].name, "_rd"}, bus.rd_data, vecs[i].exp_rd);
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 32'h0, 32'h0);

    // Single byte: first negedge after the store edge still idle, then start bit.
    @(negedge clk);
    sb.push_back(8'h55);
    storeWord(TXA, 32'hABCD_0055);
    @(negedge clk);
    checkOutput("single_tx_before_pop", 32'(tx), 32'h1);
    checkOutput("single_busy_rise", 32'(busy), 32'h1);
    @(negedge clk);
    checkOutput("single_tx_start", 32'(tx), 32'h0);
    n = 2;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("single_busy_cycles", 32'(n), 32'd41);
    waitIdle(100, "single");

    // Nine bytes fit because the first pops immediately; the tenth overflows.
    @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) sb.push_back(8'(i));
      storeWord(TXA, 32'(i));
    end
    readStatus(32'h0000_080E, "ovf_status");
    storeWord(STA, 32'h0000_0008);
    readStatus(32'h0000_0806, "ovf_cleared");
    waitIdle(1000, "ovf");
    readStatus(32'h0000_0001, "ovf_idle_status");
    checkOutput("ovf_sb_drained", 32'(sb.size()), 32'h0);

    // Back-to-back frames are separated by exactly one idle cycle.
    @(negedge clk);
    starts.delete();
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    storeWord(TXA, 32'h0000_00A5);
    storeWord(TXA, 32'h0000_003C);
    waitIdle(300, "b2b");
    checkOutput("b2b_frames", 32'(starts.size()), 32'd2);
    if (starts.size() >= 2) begin
      checkOutput("b2b_period", 32'(starts[1] - starts[0]), 32'd41);
    end

    // Full FIFO, idle FSM pops on the same edge a new store lands.
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      sb.push_back(8'(8'h10 + i));
      storeWord(TXA, 32'(8'h10 + i));
    end
    repeat (33) @(posedge clk);
    #1;
    readStatus(32'h0000_0806, "popfull_before");
    sb.push_back(8'h77);
    storeWord(TXA, 32'h0000_0077);
    readStatus(32'h0000_0806, "popfull_after");
    waitIdle(1000, "popfull");

    // Reset in the middle of a data bit with three bytes still queued.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      storeWord(TXA, 32'(8'h61 + i));
    end
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_tx", 32'(tx), 32'h1);
    checkOutput("rst_mid_busy", 32'(busy), 32'h0);
    readStatus(32'h0000_0001, "rst_mid_status");
    frames_before = frames_seen;
    low = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    checkOutput("rst_no_resume_low", 32'(low), 32'h0);
    checkOutput("rst_no_frames", 32'(frames_seen - frames_before), 32'h0);
    checkOutput("final_sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
